// File: rtl/tcam_search_engine_if.sv
// rtl/tcam_search_engine_if.sv - write and search bus of the ternary CAM search engine
interface tcam_search_engine_if #(
  parameter int MEM_SIZE   = 16,
  parameter int MEM_LENGTH = 16,
  parameter int ADDR_W     = $clog2(MEM_SIZE),
  parameter int CNT_W      = $clog2(MEM_SIZE + 1)
);
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [MEM_LENGTH-1:0] wr_data;
  logic [MEM_LENGTH-1:0] wr_mask;
  logic                  wr_valid;
  logic                  search_start;
  logic [MEM_LENGTH-1:0] search_key;
  logic                  busy;
  logic                  done;
  logic                  hit;
  logic [ADDR_W-1:0]     hit_addr;
  logic [CNT_W-1:0]      hit_count;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask, wr_valid, search_start, search_key,
    input  busy, done, hit, hit_addr, hit_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask, wr_valid, search_start, search_key,
    output busy, done, hit, hit_addr, hit_count
  );
endinterface

// File: rtl/tcam_search_engine.sv
// rtl/tcam_search_engine.sv - ternary CAM storage with a one-entry-per-clock search scan
module tcam_search_engine #(
  parameter int MEM_SIZE   = 16,
  parameter int MEM_LENGTH = 16,
  parameter int ADDR_W     = $clog2(MEM_SIZE),
  parameter int CNT_W      = $clog2(MEM_SIZE + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  tcam_search_engine_if.slave bus
);

  typedef enum logic {IDLE_S, SCAN_S} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [MEM_LENGTH-1:0] key_q, key_d;
  logic                  hit_q, hit_d;
  logic                  done_q, done_d;
  logic [ADDR_W-1:0]     hit_addr_q, hit_addr_d;
  logic [CNT_W-1:0]      hit_count_q, hit_count_d;

  logic [MEM_LENGTH-1:0] data_q [MEM_SIZE];
  logic [MEM_LENGTH-1:0] data_d [MEM_SIZE];
  logic [MEM_LENGTH-1:0] mask_q [MEM_SIZE];
  logic [MEM_LENGTH-1:0] mask_d [MEM_SIZE];
  logic [MEM_SIZE-1:0]   valid_q, valid_d;

  logic                  entry_match;

  // Entry under idx matched against current (pre-write) contents; masked bits are don't-care
  assign entry_match = valid_q[idx_q] &&
                       (((data_q[idx_q] ^ key_q) & ~mask_q[idx_q]) == '0);

  // Storage update: at most one entry written per cycle, in any state
  always_comb begin
    data_d  = data_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    if (bus.wr_en) begin
      data_d[bus.wr_addr]  = bus.wr_data;
      mask_d[bus.wr_addr]  = bus.wr_mask;
      valid_d[bus.wr_addr] = bus.wr_valid;
    end
  end

  // Search sequencing: accept in IDLE, evaluate one entry per edge, pulse done after the last
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    key_d       = key_q;
    hit_d       = hit_q;
    hit_addr_d  = hit_addr_q;
    hit_count_d = hit_count_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE_S: begin
        if (bus.search_start) begin
          state_d     = SCAN_S;
          key_d       = bus.search_key;
          idx_d       = '0;
          hit_d       = 1'b0;
          hit_addr_d  = '0;
          hit_count_d = '0;
        end
      end
      SCAN_S: begin
        if (entry_match) begin
          hit_count_d = hit_count_q + CNT_W'(1);
          if (!hit_q) begin
            hit_d      = 1'b1;
            hit_addr_d = idx_q;
          end
        end
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(MEM_SIZE - 1)) begin
          state_d = IDLE_S;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  // Control, result and valid registers; reset aborts a scan without a done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE_S;
      idx_q       <= '0;
      key_q       <= '0;
      hit_q       <= 1'b0;
      done_q      <= 1'b0;
      hit_addr_q  <= '0;
      hit_count_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      key_q       <= key_d;
      hit_q       <= hit_d;
      done_q      <= done_d;
      hit_addr_q  <= hit_addr_d;
      hit_count_q <= hit_count_d;
      valid_q     <= valid_d;
    end
  end

  // Entry payload; left untouched by reset since invalid entries never match
  always_ff @(posedge clk) begin
    data_q <= data_d;
    mask_q <= mask_d;
  end

  assign bus.busy      = (state_q == SCAN_S);
  assign bus.done      = done_q;
  assign bus.hit       = hit_q;
  assign bus.hit_addr  = hit_addr_q;
  assign bus.hit_count = hit_count_q;

endmodule

// File: tb/tb_tcam_search_engine.sv
// tb/tb_tcam_search_engine.sv - self-checking bench for tcam_search_engine
module tb_tcam_search_engine;
  localparam int MEM_SIZE   = 16;
  localparam int MEM_LENGTH = 16;
  localparam int ADDR_W     = 4;
  localparam int CNT_W      = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tcam_search_engine_if #(.MEM_SIZE(MEM_SIZE), .MEM_LENGTH(MEM_LENGTH),
                          .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  tcam_search_engine #(.MEM_SIZE(MEM_SIZE), .MEM_LENGTH(MEM_LENGTH),
                       .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int          o;
    int          addr;
    logic [15:0] d;
    logic [15:0] m;
    logic        v;
  } wr_t;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_data  [MEM_SIZE];
  logic [15:0] m_mask  [MEM_SIZE];
  logic        m_valid [MEM_SIZE];
  wr_t         pend[$];

  int          obs_done_at, obs_n_done, obs_n_busy;
  logic        obs_held, obs_hit;
  logic [3:0]  obs_addr;
  logic [4:0]  obs_cnt;
  logic        r_busy, r_done, r_hit;
  logic [3:0]  r_addr;
  logic [4:0]  r_cnt;

  logic        e_hit;
  logic [3:0]  e_addr;
  logic [4:0]  e_cnt;

  // Reference: an entry matches when valid and every unmasked bit equals the key.
  // A write at offset o after accept lands on edge k+o; entry j is read on edge k+1+j.
  function automatic void model_eval(input logic [15:0] key, output logic h,
                                     output logic [3:0] a, output logic [4:0] c);
    logic [15:0] d, mk;
    logic        v;
    h = 1'b0; a = 4'd0; c = 5'd0;
    for (int j = 0; j < MEM_SIZE; j++) begin
      d = m_data[j]; mk = m_mask[j]; v = m_valid[j];
      foreach (pend[i]) if (pend[i].addr == j && pend[i].o <= j) begin
        d = pend[i].d; mk = pend[i].m; v = pend[i].v;
      end
      if (v && (((d ~^ key) | mk) == 16'hFFFF)) begin
        if (!h) begin h = 1'b1; a = 4'(j); end
        c = c + 5'd1;
      end
    end
  endfunction

  function automatic void commit_pend();
    foreach (pend[i]) begin
      m_data[pend[i].addr]  = pend[i].d;
      m_mask[pend[i].addr]  = pend[i].m;
      m_valid[pend[i].addr] = pend[i].v;
    end
    pend.delete();
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < MEM_SIZE; j++) m_valid[j] = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [15:0] d, input logic [15:0] mk, input logic v);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 4'(a); bus.wr_data = d; bus.wr_mask = mk; bus.wr_valid = v;
    @(negedge clk);
    bus.wr_en = 1'b0;
    m_data[a] = d; m_mask[a] = mk; m_valid[a] = v;
  endtask

  task automatic drive_pending(input int o);
    foreach (pend[i]) if (pend[i].o == o) begin
      bus.wr_en = 1'b1; bus.wr_addr = 4'(pend[i].addr);
      bus.wr_data = pend[i].d; bus.wr_mask = pend[i].m; bus.wr_valid = pend[i].v;
    end
  endtask

  // Runs one search with the pending writes; records what the DUT shows after each edge
  task automatic run_search(input logic [15:0] key, input int ign_at, input int rst_at);
    obs_done_at = -1; obs_n_done = 0; obs_n_busy = 0; obs_held = 1'b1;
    obs_hit = 1'b0; obs_addr = 4'd0; obs_cnt = 5'd0;
    r_busy = 1'b1; r_done = 1'b1; r_hit = 1'b1; r_addr = 4'hF; r_cnt = 5'h1F;
    @(negedge clk);
    bus.search_start = 1'b1; bus.search_key = key;
    drive_pending(0);
    @(negedge clk);
    for (int m = 0; m <= MEM_SIZE + 3; m++) begin
      if (bus.busy) obs_n_busy++;
      if (bus.done) obs_n_done++;
      if (bus.done && obs_done_at < 0) begin
        obs_done_at = m; obs_hit = bus.hit; obs_addr = bus.hit_addr; obs_cnt = bus.hit_count;
      end else if (obs_done_at >= 0 &&
                   (bus.hit !== obs_hit || bus.hit_addr !== obs_addr || bus.hit_count !== obs_cnt)) begin
        obs_held = 1'b0;
      end
      if (m == rst_at) begin
        r_busy = bus.busy; r_done = bus.done; r_hit = bus.hit;
        r_addr = bus.hit_addr; r_cnt = bus.hit_count;
      end
      bus.search_start = 1'b0; bus.wr_en = 1'b0; rst_n = 1'b1;
      drive_pending(m + 1);
      if (m + 1 == ign_at) begin bus.search_start = 1'b1; bus.search_key = 16'h0000; end
      if (m + 1 == rst_at) rst_n = 1'b0;
      @(negedge clk);
    end
    bus.search_start = 1'b0; bus.wr_en = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0d expected 0", bus.done); end
    checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0d expected 0", bus.hit); end
    checks++; if (bus.hit_addr !== 4'd0) begin errors++; $display("FAIL reset_hit_addr: got %0d expected 0", bus.hit_addr); end
    checks++; if (bus.hit_count !== 5'd0) begin errors++; $display("FAIL reset_hit_count: got %0d expected 0", bus.hit_count); end
    run_search(16'hFFFF, -1, -1);
    checks++; if (obs_n_busy != MEM_SIZE) begin errors++; $display("FAIL empty_busy_cycles: got %0d expected %0d", obs_n_busy, MEM_SIZE); end
    checks++; if (obs_done_at != MEM_SIZE) begin errors++; $display("FAIL empty_done_time: got %0d expected %0d", obs_done_at, MEM_SIZE); end
    checks++; if (obs_n_done != 1) begin errors++; $display("FAIL empty_done_pulses: got %0d expected 1", obs_n_done); end
    checks++; if ({obs_hit, obs_addr, obs_cnt} !== 10'd0) begin errors++;
      $display("FAIL empty_result: got hit=%0d addr=%0d cnt=%0d expected 0/0/0", obs_hit, obs_addr, obs_cnt); end
  endtask

  task automatic test_exact_masked();
    logic [15:0] keys [3];
    keys[0] = 16'h12AB; keys[1] = 16'h12CD; keys[2] = 16'h13AB;
    do_write(3, 16'h12AB, 16'h0000, 1'b1);
    do_write(7, 16'h1200, 16'h00FF, 1'b1);
    for (int t = 0; t < 3; t++) begin
      model_eval(keys[t], e_hit, e_addr, e_cnt);
      run_search(keys[t], -1, -1);
      checks++; if ({obs_hit, obs_addr, obs_cnt} !== {e_hit, e_addr, e_cnt} || obs_done_at != MEM_SIZE) begin errors++;
        $display("FAIL exact_masked key=%h: got hit=%0d addr=%0d cnt=%0d t=%0d expected %0d/%0d/%0d t=%0d",
                 keys[t], obs_hit, obs_addr, obs_cnt, obs_done_at, e_hit, e_addr, e_cnt, MEM_SIZE); end
    end
  endtask

  task automatic test_invalidate_full();
    do_write(3, 16'h12AB, 16'h0000, 1'b0);
    run_search(16'h12AB, -1, -1);
    checks++; if (obs_hit !== 1'b1 || obs_addr !== 4'd7 || obs_cnt !== 5'd1) begin errors++;
      $display("FAIL invalidate: got hit=%0d addr=%0d cnt=%0d expected 1/7/1", obs_hit, obs_addr, obs_cnt); end
    for (int j = 0; j < MEM_SIZE; j++) do_write(j, 16'($urandom), 16'hFFFF, 1'b1);
    run_search(16'h0000, -1, -1);
    checks++; if (obs_hit !== 1'b1 || obs_addr !== 4'd0 || obs_cnt !== 5'd16) begin errors++;
      $display("FAIL full_match: got hit=%0d addr=%0d cnt=%0d expected 1/0/16", obs_hit, obs_addr, obs_cnt); end
  endtask

  task automatic test_write_during_scan();
    for (int j = 0; j < MEM_SIZE; j++) do_write(j, 16'h0000, 16'h0000, 1'b0);
    pend.push_back('{o: 2, addr: 15, d: 16'h5555, m: 16'h0000, v: 1'b1});
    pend.push_back('{o: 3, addr: 0,  d: 16'h5555, m: 16'h0000, v: 1'b1});
    pend.push_back('{o: 6, addr: 5,  d: 16'h5555, m: 16'h0000, v: 1'b1});
    run_search(16'h5555, -1, -1);
    checks++; if (obs_hit !== 1'b1 || obs_addr !== 4'd15 || obs_cnt !== 5'd1) begin errors++;
      $display("FAIL write_during_scan: got hit=%0d addr=%0d cnt=%0d expected 1/15/1", obs_hit, obs_addr, obs_cnt); end
    checks++; if (obs_held !== 1'b1) begin errors++; $display("FAIL results_held: got %0d expected 1", obs_held); end
    commit_pend();
    run_search(16'h5555, -1, -1);
    checks++; if (obs_addr !== 4'd0 || obs_cnt !== 5'd3) begin errors++;
      $display("FAIL writes_landed: got addr=%0d cnt=%0d expected 0/3", obs_addr, obs_cnt); end
  endtask

  task automatic test_ignored_start();
    run_search(16'h5555, 4, -1);
    checks++; if (obs_done_at != MEM_SIZE || obs_n_done != 1) begin errors++;
      $display("FAIL ignored_start_timing: got t=%0d pulses=%0d expected %0d/1", obs_done_at, obs_n_done, MEM_SIZE); end
    checks++; if (obs_hit !== 1'b1 || obs_addr !== 4'd0 || obs_cnt !== 5'd3) begin errors++;
      $display("FAIL ignored_start_result: got hit=%0d addr=%0d cnt=%0d expected 1/0/3", obs_hit, obs_addr, obs_cnt); end
  endtask

  task automatic test_reset_mid_scan();
    run_search(16'h5555, -1, 5);
    for (int j = 0; j < MEM_SIZE; j++) m_valid[j] = 1'b0;
    checks++; if ({r_busy, r_done, r_hit, r_addr, r_cnt} !== 12'd0) begin errors++;
      $display("FAIL reset_mid_scan_outputs: got busy=%0d done=%0d hit=%0d addr=%0d cnt=%0d expected all 0",
               r_busy, r_done, r_hit, r_addr, r_cnt); end
    checks++; if (obs_n_done != 0) begin errors++; $display("FAIL reset_mid_scan_done: got %0d pulses expected 0", obs_n_done); end
    model_eval(16'h5555, e_hit, e_addr, e_cnt);
    run_search(16'h5555, -1, -1);
    checks++; if (obs_hit !== e_hit || obs_cnt !== e_cnt || obs_done_at != MEM_SIZE) begin errors++;
      $display("FAIL after_reset_search: got hit=%0d cnt=%0d t=%0d expected %0d/%0d/%0d",
               obs_hit, obs_cnt, obs_done_at, e_hit, e_cnt, MEM_SIZE); end
  endtask

  task automatic test_random();
    logic [15:0] key;
    int          src;
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < MEM_SIZE; j++)
        do_write(j, 16'($urandom), 16'($urandom & $urandom & $urandom), ($urandom_range(0, 3) != 0));
      for (int o = 0; o <= MEM_SIZE + 1; o++)
        if ($urandom_range(0, 2) == 0)
          pend.push_back('{o: o, addr: $urandom_range(0, MEM_SIZE - 1), d: 16'($urandom),
                           m: 16'($urandom & $urandom), v: 1'b1});
      src = $urandom_range(0, MEM_SIZE - 1);
      key = ($urandom_range(0, 4) == 0) ? 16'($urandom) : (m_data[src] ^ (16'($urandom) & m_mask[src]));
      if (pend.size() > 0 && $urandom_range(0, 1) == 0) key = pend[0].d;
      model_eval(key, e_hit, e_addr, e_cnt);
      run_search(key, -1, -1);
      checks++; if ({obs_hit, obs_addr, obs_cnt} !== {e_hit, e_addr, e_cnt} || obs_done_at != MEM_SIZE
                    || obs_n_done != 1 || obs_held !== 1'b1) begin errors++;
        $display("FAIL random_%0d key=%h: got hit=%0d addr=%0d cnt=%0d t=%0d n=%0d held=%0d expected %0d/%0d/%0d t=%0d n=1 held=1",
                 it, key, obs_hit, obs_addr, obs_cnt, obs_done_at, obs_n_done, obs_held,
                 e_hit, e_addr, e_cnt, MEM_SIZE); end
      commit_pend();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0; bus.wr_valid = 1'b0;
    bus.search_start = 1'b0; bus.search_key = '0;
    for (int j = 0; j < MEM_SIZE; j++) begin m_data[j] = '0; m_mask[j] = '0; m_valid[j] = 1'b0; end
    test_reset();
    test_exact_masked();
    test_invalidate_full();
    test_write_during_scan();
    test_ignored_start();
    test_reset_mid_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
